// File: rtl/spmv_result_accum.sv
// spmv_result_accum
// Collects per-row partial products from the SpMV multiplier into a row-indexed
// result RAM, then streams rows 0..max_addr out over valid/ready and re-clears
// the RAM for the next matrix. Accumulation is a 2-stage read-modify-write with
// forwarding, so repeated rows accumulate at one beat per cycle.
module spmv_result_accum #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_zeros,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SUM_W = DATA_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [ADDR_W-1:0] max_addr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              busy_r;
  logic              ovf_r;

  // Stage A: accepted beat, RAM read in flight
  logic              a_valid_r;
  logic              a_zeros_r;
  logic [ADDR_W-1:0] a_addr_r;
  logic [DATA_W-1:0] a_op1_r;
  logic [DATA_W-1:0] a_op2_r;

  // Stage B: RAM data available, sum computed and written this cycle
  logic              b_valid_r;
  logic              b_zeros_r;
  logic [ADDR_W-1:0] b_addr_r;
  logic [DATA_W-1:0] b_op1_r;
  logic [DATA_W-1:0] b_op2_r;

  // Forwarded stage-B result replacing the (stale) read-first RAM output
  logic              fwd_r;
  logic [DATA_W-1:0] fwd_val_r;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q_r;

  logic              accept_s;
  logic              hs_s;
  logic              drain_load_s;
  logic [DATA_W-1:0] base_s;
  logic [SUM_W-1:0]  sum_s;
  logic [DATA_W-1:0] b_sum_s;
  logic              b_carry_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              we_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign accept_s     = in_valid && in_ready_r;
  assign hs_s         = out_valid_r && out_ready;
  assign drain_load_s = (state_r == DRAIN) && (!out_valid_r || (hs_s && !out_last_r));

  // Stage-B sum: forwarded or RAM base plus both partial products; zero rows force 0.
  always_comb begin
    base_s    = rd_q_r;
    b_sum_s   = DATA_ZERO;
    b_carry_s = 1'b0;
    if (fwd_r) begin
      base_s = fwd_val_r;
    end else begin
      base_s = rd_q_r;
    end
    sum_s = {2'b00, base_s} + {2'b00, b_op1_r} + {2'b00, b_op2_r};
    if (b_zeros_r) begin
      b_sum_s   = DATA_ZERO;
      b_carry_s = 1'b0;
    end else begin
      b_sum_s   = sum_s[DATA_W-1:0];
      b_carry_s = |sum_s[SUM_W-1:DATA_W];
    end
  end

  // RAM port steering: drain reads the prefetch pointer (or re-reads the held row when stalled).
  always_comb begin
    rd_addr_s = a_addr_r;
    we_s      = 1'b0;
    wr_addr_s = clr_cnt_r;
    wr_data_s = DATA_ZERO;
    if (state_r == DRAIN) begin
      if (drain_load_s) begin
        rd_addr_s = rd_ptr_r;
      end else begin
        rd_addr_s = out_addr_r;
      end
    end else begin
      rd_addr_s = a_addr_r;
    end
    if (reset) begin
      we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      we_s      = 1'b1;
      wr_addr_s = clr_cnt_r;
      wr_data_s = DATA_ZERO;
    end else if (b_valid_r) begin
      we_s      = 1'b1;
      wr_addr_s = b_addr_r;
      wr_data_s = b_sum_s;
    end else begin
      we_s = 1'b0;
    end
  end

  // RAM write port: clear sweep or stage-B accumulate result.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

  // RAM read port (read-first); doubles as the out_data register during drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_r <= DATA_ZERO;
    end else begin
      rd_q_r <= mem[rd_addr_s];
    end
  end

  // Read-modify-write pipeline registers and same-row forwarding capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_r <= 1'b0;
      a_zeros_r <= 1'b0;
      a_addr_r  <= ADDR_ZERO;
      a_op1_r   <= DATA_ZERO;
      a_op2_r   <= DATA_ZERO;
      b_valid_r <= 1'b0;
      b_zeros_r <= 1'b0;
      b_addr_r  <= ADDR_ZERO;
      b_op1_r   <= DATA_ZERO;
      b_op2_r   <= DATA_ZERO;
      fwd_r     <= 1'b0;
      fwd_val_r <= DATA_ZERO;
    end else begin
      a_valid_r <= accept_s;
      if (accept_s) begin
        a_zeros_r <= in_zeros;
        a_addr_r  <= in_addr;
        a_op1_r   <= in_op1;
        a_op2_r   <= in_op2;
      end
      b_valid_r <= a_valid_r;
      b_zeros_r <= a_zeros_r;
      b_addr_r  <= a_addr_r;
      b_op1_r   <= a_op1_r;
      b_op2_r   <= a_op2_r;
      fwd_r     <= a_valid_r && b_valid_r && (a_addr_r == b_addr_r);
      fwd_val_r <= b_sum_s;
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= ADDR_ZERO;
      max_addr_r  <= ADDR_ZERO;
      rd_ptr_r    <= ADDR_ZERO;
      out_addr_r  <= ADDR_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b1;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          ovf_r      <= 1'b0;
          max_addr_r <= ADDR_ZERO;
          clr_cnt_r  <= clr_cnt_r + ADDR_ONE;
          if (clr_cnt_r == ADDR_LAST) begin
            state_r    <= ACCUM;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ACCUM: begin
          if (b_valid_r && b_carry_s) begin
            ovf_r <= 1'b1;
          end
          if (accept_s) begin
            if (in_addr > max_addr_r) begin
              max_addr_r <= in_addr;
            end
            if (in_last) begin
              state_r    <= FLUSH;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (b_valid_r && b_carry_s) begin
            ovf_r <= 1'b1;
          end
          // Leaving once stage A is empty lets the final stage-B write land on the same edge.
          if (!a_valid_r) begin
            state_r  <= DRAIN;
            rd_ptr_r <= ADDR_ZERO;
          end
        end
        DRAIN: begin
          if (hs_s && out_last_r) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            state_r     <= CLEAR;
            clr_cnt_r   <= ADDR_ZERO;
          end else if (drain_load_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= rd_ptr_r;
            out_last_r  <= (rd_ptr_r == max_addr_r);
            rd_ptr_r    <= rd_ptr_r + ADDR_ONE;
          end
        end
        default: begin
          state_r     <= CLEAR;
          clr_cnt_r   <= ADDR_ZERO;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_addr  = out_addr_r;
  assign out_data  = rd_q_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule
